// File: rtl/alu_execute_stage.sv
// Execute stage: single-cycle ALU ops plus an optional iterative shift-add multiplier.
// Optional feature macro: ALU_MUL_EN (multiplier and MUL_BUSY state built only when defined).
module alu_execute_stage #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [3:0]        i_opcode,
   input  logic [DATA_W-1:0] i_srcdata1,
   input  logic [DATA_W-1:0] i_srcdata2,
   input  logic [ADDR_W-1:0] i_destadd,
   output logic              o_write_en,
   output logic [ADDR_W-1:0] o_write_add,
   output logic [DATA_W-1:0] o_write_data,
   output logic              o_zero,
   output logic              o_carry,
   output logic              o_illegal
);

   localparam int unsigned SHAMT_W = $clog2(DATA_W);
   localparam int unsigned PROD_W  = 2 * DATA_W;

   localparam logic [3:0] OP_ADD    = 4'b0001;
   localparam logic [3:0] OP_SUB    = 4'b0010;
   localparam logic [3:0] OP_AND    = 4'b0011;
   localparam logic [3:0] OP_LSHIFT = 4'b0100;
   localparam logic [3:0] OP_OR     = 4'b0101;
   localparam logic [3:0] OP_XOR    = 4'b0110;
   localparam logic [3:0] OP_RSHIFT = 4'b1000;
`ifdef ALU_MUL_EN
   localparam logic [3:0] OP_MUL    = 4'b0111;
`endif

   typedef enum logic {
      S_IDLE,
      S_MUL_BUSY
   } state_e;

   state_e              state_q, state_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_add_q, wr_add_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic                zero_q, zero_d;
   logic                carry_q, carry_d;
   logic                illegal_q, illegal_d;

`ifdef ALU_MUL_EN
   logic [PROD_W-1:0]   acc_q, acc_d;
   logic [PROD_W-1:0]   mcand_q, mcand_d;
   logic [DATA_W-1:0]   mplier_q, mplier_d;
   logic [SHAMT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0]   dest_q, dest_d;
   logic [PROD_W-1:0]   mul_sum;
`endif

   logic [SHAMT_W-1:0]  shamt;
   logic [DATA_W:0]     sum_full;
   logic [DATA_W:0]     diff_full;
   logic [DATA_W:0]     shl_full;
   logic [DATA_W:0]     shr_full;
   logic [DATA_W-1:0]   alu_res;
   logic                alu_carry;
   logic                alu_legal;

   assign o_ready      = (state_q == S_IDLE);
   assign o_write_en   = wr_en_q;
   assign o_write_add  = wr_add_q;
   assign o_write_data = wr_data_q;
   assign o_zero       = zero_q;
   assign o_carry      = carry_q;
   assign o_illegal    = illegal_q;

   // Single-cycle ALU; the extra top/bottom bit of each wide result carries the flag.
   always_comb begin
      shamt     = i_srcdata2[SHAMT_W-1:0];
      sum_full  = {1'b0, i_srcdata1} + {1'b0, i_srcdata2};
      diff_full = {1'b0, i_srcdata1} - {1'b0, i_srcdata2};
      shl_full  = {1'b0, i_srcdata1} << shamt;
      shr_full  = {i_srcdata1, 1'b0} >> shamt;
      alu_res   = '0;
      alu_carry = 1'b0;
      alu_legal = 1'b1;
      case (i_opcode)
         OP_ADD: begin
            alu_res   = sum_full[DATA_W-1:0];
            alu_carry = sum_full[DATA_W];
         end
         OP_SUB: begin
            alu_res   = diff_full[DATA_W-1:0];
            alu_carry = diff_full[DATA_W];
         end
         OP_AND:    alu_res = i_srcdata1 & i_srcdata2;
         OP_OR:     alu_res = i_srcdata1 | i_srcdata2;
         OP_XOR:    alu_res = i_srcdata1 ^ i_srcdata2;
         OP_LSHIFT: begin
            alu_res   = shl_full[DATA_W-1:0];
            alu_carry = shl_full[DATA_W];
         end
         OP_RSHIFT: begin
            alu_res   = shr_full[DATA_W:1];
            alu_carry = shr_full[0];
         end
         default:   alu_legal = 1'b0;
      endcase
   end

`ifdef ALU_MUL_EN
   assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

   // Next-state and result-register logic.
   always_comb begin
      state_d   = state_q;
      wr_en_d   = 1'b0;
      illegal_d = 1'b0;
      wr_add_d  = wr_add_q;
      wr_data_d = wr_data_q;
      zero_d    = zero_q;
      carry_d   = carry_q;
`ifdef ALU_MUL_EN
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      cnt_d     = cnt_q;
      dest_d    = dest_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (i_valid) begin
               if (alu_legal) begin
                  wr_en_d   = 1'b1;
                  wr_add_d  = i_destadd;
                  wr_data_d = alu_res;
                  zero_d    = (alu_res == '0);
                  carry_d   = alu_carry;
               end
`ifdef ALU_MUL_EN
               else if (i_opcode == OP_MUL) begin
                  state_d  = S_MUL_BUSY;
                  acc_d    = '0;
                  mcand_d  = {{DATA_W{1'b0}}, i_srcdata1};
                  mplier_d = i_srcdata2;
                  cnt_d    = '0;
                  dest_d   = i_destadd;
               end
`endif
               else begin
                  illegal_d = 1'b1;
               end
            end
         end
`ifdef ALU_MUL_EN
         S_MUL_BUSY: begin
            acc_d    = mul_sum;
            mcand_d  = {mcand_q[PROD_W-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[DATA_W-1:1]};
            cnt_d    = cnt_q + SHAMT_W'(1);
            // Last iteration: publish the product in the same edge that returns to IDLE.
            if (cnt_q == SHAMT_W'(DATA_W - 1)) begin
               state_d   = S_IDLE;
               wr_en_d   = 1'b1;
               wr_add_d  = dest_q;
               wr_data_d = mul_sum[DATA_W-1:0];
               zero_d    = (mul_sum[DATA_W-1:0] == '0);
               carry_d   = (mul_sum[PROD_W-1:DATA_W] != '0);
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q   <= S_IDLE;
         wr_en_q   <= 1'b0;
         wr_add_q  <= '0;
         wr_data_q <= '0;
         zero_q    <= 1'b0;
         carry_q   <= 1'b0;
         illegal_q <= 1'b0;
`ifdef ALU_MUL_EN
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         cnt_q     <= '0;
         dest_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         wr_en_q   <= wr_en_d;
         wr_add_q  <= wr_add_d;
         wr_data_q <= wr_data_d;
         zero_q    <= zero_d;
         carry_q   <= carry_d;
         illegal_q <= illegal_d;
`ifdef ALU_MUL_EN
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         cnt_q     <= cnt_d;
         dest_q    <= dest_d;
`endif
      end
   end

endmodule

// File: tb/tb_alu_execute_stage.sv
// Scoreboard bench for alu_execute_stage: directed vectors push expected responses,
// a forked monitor pops and compares on every write strobe or illegal pulse.
module tb_alu_execute_stage;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 4;

   logic              i_clk;
   logic              i_reset;
   logic              i_valid;
   logic              o_ready;
   logic [3:0]        i_opcode;
   logic [DATA_W-1:0] i_srcdata1;
   logic [DATA_W-1:0] i_srcdata2;
   logic [ADDR_W-1:0] i_destadd;
   logic              o_write_en;
   logic [ADDR_W-1:0] o_write_add;
   logic [DATA_W-1:0] o_write_data;
   logic              o_zero;
   logic              o_carry;
   logic              o_illegal;

   typedef struct {
      logic              ill;
      logic [ADDR_W-1:0] add;
      logic [DATA_W-1:0] data;
      logic              z;
      logic              c;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   alu_execute_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .i_opcode     (i_opcode),
      .i_srcdata1   (i_srcdata1),
      .i_srcdata2   (i_srcdata2),
      .i_destadd    (i_destadd),
      .o_write_en   (o_write_en),
      .o_write_add  (o_write_add),
      .o_write_data (o_write_data),
      .o_zero       (o_zero),
      .o_carry      (o_carry),
      .o_illegal    (o_illegal)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic monitor();
      exp_t e;
      int   n = 0;
      forever begin
         @(negedge i_clk);
         if (i_reset && (o_write_en || o_illegal)) begin
            tests++;
            n++;
            if (sb.size() == 0) begin
               fails++;
               $display("FAIL resp#%0d: unexpected en=%b ill=%b add=%h data=%h", n,
                        o_write_en, o_illegal, o_write_add, o_write_data);
            end else begin
               e = sb.pop_front();
               if (e.ill) begin
                  if (!(o_illegal && !o_write_en)) begin
                     fails++;
                     $display("FAIL resp#%0d: got en=%b ill=%b expected en=0 ill=1", n,
                              o_write_en, o_illegal);
                  end
               end else if (!(o_write_en && !o_illegal && o_write_add == e.add &&
                              o_write_data == e.data && o_zero == e.z && o_carry == e.c)) begin
                  fails++;
                  $display("FAIL resp#%0d: got en=%b ill=%b add=%h data=%h z=%b c=%b expected en=1 ill=0 add=%h data=%h z=%b c=%b",
                           n, o_write_en, o_illegal, o_write_add, o_write_data, o_zero, o_carry,
                           e.add, e.data, e.z, e.c);
               end
            end
         end
      end
   endtask

   // Present an op, wait (bounded) for acceptance, optionally record its expected response.
   task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] d, input bit push, input logic ill,
                       input logic [7:0] data, input logic z, input logic c);
      int   guard = 0;
      exp_t e;
      i_valid    = 1'b1;
      i_opcode   = op;
      i_srcdata1 = a;
      i_srcdata2 = b;
      i_destadd  = d;
      while (!o_ready && guard < 100) begin
         @(posedge i_clk);
         #1;
         guard++;
      end
      if (guard >= 100) begin
         tests++;
         fails++;
         $display("FAIL accept_timeout: o_ready=%b expected 1", o_ready);
      end
      if (push) begin
         e.ill = ill; e.add = d; e.data = data; e.z = z; e.c = c;
         sb.push_back(e);
      end
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
   endtask

   task automatic wr(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic [3:0] d, input logic [7:0] data, input logic z, input logic c);
      send(op, a, b, d, 1'b1, 1'b0, data, z, c);
   endtask

   task automatic bad(input logic [3:0] op, input logic [3:0] d);
      send(op, 8'h11, 8'h22, d, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

`ifdef ALU_MUL_EN
   // Issue a MUL and count the cycles o_ready stays low afterwards.
   task automatic mul_check(input logic [7:0] a, input logic [7:0] b, input logic [3:0] d,
                            input logic [7:0] data, input logic z, input logic c);
      int lows = 0;
      wr(4'b0111, a, b, d, data, z, c);
      i_srcdata1 = 8'h00;
      i_srcdata2 = 8'h00;
      i_destadd  = 4'h0;
      while (!o_ready && lows < 50) begin
         @(negedge i_clk);
         if (!o_ready) lows++;
      end
      check("mul_ready_low_cycles", 32'(lows), 32'(DATA_W));
      #1;
   endtask
`endif

   initial begin
      i_reset    = 1'b0;
      i_valid    = 1'b0;
      i_opcode   = 4'h0;
      i_srcdata1 = '0;
      i_srcdata2 = '0;
      i_destadd  = '0;
      fork
         monitor();
      join_none
      idle(3);
      check("reset_outputs", {26'(0), o_write_en, o_illegal, o_zero, o_carry, o_ready, 1'b0},
            32'h0000_0002);
      check("reset_data_add", {20'(0), o_write_add, o_write_data}, 32'h0);
      #2 i_reset = 1'b1;
      idle(2);

      wr(4'b0001, 8'hF0, 8'h20, 4'h3, 8'h10, 1'b0, 1'b1);
      wr(4'b0010, 8'h05, 8'h05, 4'h4, 8'h00, 1'b1, 1'b0);
      wr(4'b0010, 8'h03, 8'h05, 4'h5, 8'hFE, 1'b0, 1'b1);
      idle(2);

      wr(4'b0001, 8'h12, 8'h34, 4'h6, 8'h46, 1'b0, 1'b0);
      wr(4'b0110, 8'hAA, 8'hFF, 4'h7, 8'h55, 1'b0, 1'b0);
      wr(4'b0100, 8'h81, 8'h01, 4'h8, 8'h02, 1'b0, 1'b1);
      wr(4'b0011, 8'hF0, 8'h3C, 4'h9, 8'h30, 1'b0, 1'b0);
      wr(4'b0101, 8'h0F, 8'hA0, 4'hA, 8'hAF, 1'b0, 1'b0);
      wr(4'b1000, 8'h81, 8'h01, 4'hB, 8'h40, 1'b0, 1'b1);
      wr(4'b1000, 8'h80, 8'h07, 4'hC, 8'h01, 1'b0, 1'b0);
      wr(4'b0100, 8'h55, 8'h00, 4'hD, 8'h55, 1'b0, 1'b0);
      wr(4'b0100, 8'h40, 8'h09, 4'hE, 8'h80, 1'b0, 1'b0);
      wr(4'b0001, 8'hFF, 8'h01, 4'hF, 8'h00, 1'b1, 1'b1);
      idle(2);

      bad(4'h0, 4'h1);
      idle(1);
      bad(4'hF, 4'h2);
      bad(4'h9, 4'h3);
      idle(2);

`ifdef ALU_MUL_EN
      mul_check(8'h0F, 8'h11, 4'h4, 8'hFF, 1'b0, 1'b0);
      mul_check(8'h10, 8'h10, 4'h5, 8'h00, 1'b1, 1'b1);
      wr(4'b0001, 8'h21, 8'h21, 4'hA, 8'h42, 1'b0, 1'b0);
      idle(2);
      // Abort a MUL mid-iteration; no write may ever appear for it.
      send(4'b0111, 8'h0F, 8'h11, 4'hB, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      idle(3);
`else
      bad(4'b0111, 4'h4);
      wr(4'b0001, 8'h21, 8'h21, 4'hA, 8'h42, 1'b0, 1'b0);
      idle(2);
`endif
      i_reset = 1'b0;
      #1;
      check("midrun_reset_outputs", {26'(0), o_write_en, o_illegal, o_zero, o_carry, o_ready, 1'b0},
            32'h0000_0002);
      check("midrun_reset_data_add", {20'(0), o_write_add, o_write_data}, 32'h0);
      idle(2);
      i_reset = 1'b1;
      #1;
      check("ready_after_release", 32'(o_ready), 32'h1);
      idle(20);

      wr(4'b0001, 8'h01, 8'h01, 4'h1, 8'h02, 1'b0, 1'b0);
      idle(3);
      check("scoreboard_drained", 32'(sb.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
